// File: rtl/regfile_scoreboard_pkg.sv
// Shared CPU constants for the register scoreboard: address width, link register
// and pending-count width helper.
package regfile_scoreboard_pkg;

  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_RA = 5'd31;

  // Bits needed to hold 0..max_pend inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Saturating per-register pending-write counter: +inc -wb -sq per cycle, clamped to
// 0..MaxPend with a fault pulse whenever a clamp or hold happens.
module sb_counter #(
  parameter int unsigned MaxPend = 3,
  parameter int unsigned CntW    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            wb_dec,
  input  logic            sq_dec,
  output logic [CntW-1:0] count,
  output logic            fault
);

  logic [CntW-1:0] count_q, count_d;
  int              sum;

  always_comb begin
    count_d = count_q;
    fault   = 1'b0;
    sum     = int'(count_q) + int'(inc) - int'(wb_dec) - int'(sq_dec);
    if (sum < 0) begin
      count_d = '0;
      fault   = 1'b1;
    end else if (sum > int'(MaxPend)) begin
      fault = 1'b1;
    end else begin
      count_d = CntW'(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight writes per register and stalls
// issue on RAW hazards or a full pending counter.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs,
  input  logic [REG_AW-1:0] issue_rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              issue_wr,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_jal,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_jal,
  input  logic              sq_valid,
  input  logic [REG_AW-1:0] sq_rd,
  input  logic              sq_jal,
  output logic              stall,
  output logic [31:0]       busy_mask,
  output logic              err
);

  localparam int unsigned CntW = cnt_width(MAX_PEND);

  logic [REG_AW-1:0]        issue_dst, wb_dst, sq_dst;
  logic [31:0][CntW-1:0]    cnt;
  logic [31:0]              fault;
  logic [CntW-1:0]          rs_cnt, rt_cnt, dst_cnt;
  logic                     rs_busy, rt_busy, dst_full, accept;
  logic                     err_q;

  assign issue_dst = issue_jal ? REG_RA : issue_rd;
  assign wb_dst    = wb_jal ? REG_RA : wb_rd;
  assign sq_dst    = sq_jal ? REG_RA : sq_rd;

  assign rs_cnt  = cnt[issue_rs];
  assign rt_cnt  = cnt[issue_rt];
  assign dst_cnt = cnt[issue_dst];

  // A same-cycle writeback lands before the read, so it credits one pending write.
  always_comb begin
    rs_busy  = use_rs && (issue_rs != '0) && (rs_cnt != '0) &&
               !(wb_valid && (wb_dst == issue_rs) && (rs_cnt == CntW'(1)));
    rt_busy  = use_rt && (issue_rt != '0) && (rt_cnt != '0) &&
               !(wb_valid && (wb_dst == issue_rt) && (rt_cnt == CntW'(1)));
    dst_full = issue_wr && (dst_cnt == CntW'(MAX_PEND)) &&
               !(wb_valid && (wb_dst == issue_dst));
    stall    = issue_valid && (rs_busy || rt_busy || dst_full);
    accept   = issue_valid && !stall;
  end

  assign cnt[0]   = '0;
  assign fault[0] = 1'b0;

  for (genvar i = 1; i < 32; i++) begin : g_cnt
    sb_counter #(
      .MaxPend (MAX_PEND),
      .CntW    (CntW)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (accept && issue_wr && (issue_dst == REG_AW'(i))),
      .wb_dec (wb_valid && (wb_dst == REG_AW'(i))),
      .sq_dec (sq_valid && (sq_dst == REG_AW'(i))),
      .count  (cnt[i]),
      .fault  (fault[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (|fault) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < 32; i++) begin
      busy_mask[i] = (cnt[i] != '0);
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with MAX_PEND=3: RAW stall, JAL forcing,
// saturation, squash/underflow, register 0 and reset override.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs = '0, issue_rt = '0, issue_rd = '0;
  logic        use_rs = 1'b0, use_rt = 1'b0, issue_wr = 1'b0, issue_jal = 1'b0;
  logic        wb_valid = 1'b0, wb_jal = 1'b0, sq_valid = 1'b0, sq_jal = 1'b0;
  logic [4:0]  wb_rd = '0, sq_rd = '0;
  logic        stall, err;
  logic [31:0] busy_mask;

  int vectors = 0;
  int miscompares = 0;

  regfile_scoreboard #(.MAX_PEND(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rs    (issue_rs),
    .issue_rt    (issue_rt),
    .use_rs      (use_rs),
    .use_rt      (use_rt),
    .issue_wr    (issue_wr),
    .issue_rd    (issue_rd),
    .issue_jal   (issue_jal),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_jal      (wb_jal),
    .sq_valid    (sq_valid),
    .sq_rd       (sq_rd),
    .sq_jal      (sq_jal),
    .stall       (stall),
    .busy_mask   (busy_mask),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next posedge; inputs are then changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; use_rs = 0; use_rt = 0; issue_wr = 0; issue_jal = 0;
    issue_rs = 0; issue_rt = 0; issue_rd = 0;
    wb_valid = 0; wb_jal = 0; wb_rd = 0;
    sq_valid = 0; sq_jal = 0; sq_rd = 0;
  endtask

  task automatic issue_write(input logic [4:0] rd);
    idle();
    issue_valid = 1; issue_wr = 1; issue_rd = rd;
  endtask

  initial begin
    // Reset
    idle();
    rst = 1;
    step();
    rst = 0;
    #1;
    check("reset_busy", busy_mask, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    check("reset_stall_idle", {31'b0, stall}, 32'h0);

    // RAW stall on r5, released by same-cycle writeback
    issue_write(5'd5);
    #1 check("raw_c0_stall", {31'b0, stall}, 32'h0);
    step();
    idle(); issue_valid = 1; use_rs = 1; issue_rs = 5'd5;
    #1 check("raw_c1_stall", {31'b0, stall}, 32'h1);
    check("raw_c1_busy5", {31'b0, busy_mask[5]}, 32'h1);
    step();
    #1 check("raw_c2_stall", {31'b0, stall}, 32'h1);
    step();
    wb_valid = 1; wb_rd = 5'd5;
    #1 check("raw_c3_stall_wb", {31'b0, stall}, 32'h0);
    step();
    idle();
    #1 check("raw_c4_busy", busy_mask, 32'h0);

    // JAL forces destination 31
    issue_write(5'd7); issue_jal = 1;
    step();
    idle();
    #1 check("jal_busy", busy_mask, 32'h8000_0000);
    wb_valid = 1; wb_jal = 1; wb_rd = 5'd3;
    step();
    idle();
    #1 check("jal_wb_busy", busy_mask, 32'h0);
    check("jal_err", {31'b0, err}, 32'h0);

    // Saturation of r9 at 3 pending writes
    for (int i = 0; i < 3; i++) begin
      issue_write(5'd9);
      #1 check("sat_issue_stall", {31'b0, stall}, 32'h0);
      step();
    end
    issue_write(5'd9);
    #1 check("sat_full_stall", {31'b0, stall}, 32'h1);
    step();
    #1 check("sat_full_err", {31'b0, err}, 32'h0);
    wb_valid = 1; wb_rd = 5'd9;
    #1 check("sat_wb_credit_stall", {31'b0, stall}, 32'h0);
    step();
    issue_write(5'd9);
    #1 check("sat_still_full_stall", {31'b0, stall}, 32'h1);
    idle();
    wb_valid = 1; wb_rd = 5'd9;
    step();
    step();
    #1 check("sat_two_wb_busy9", {31'b0, busy_mask[9]}, 32'h1);
    step();
    idle();
    #1 check("sat_drain_busy", busy_mask, 32'h0);
    check("sat_drain_err", {31'b0, err}, 32'h0);

    // Squash: no same-cycle credit, then underflow
    issue_write(5'd4);
    step();
    idle();
    #1 check("sq_busy4", {31'b0, busy_mask[4]}, 32'h1);
    issue_valid = 1; use_rt = 1; issue_rt = 5'd4;
    sq_valid = 1; sq_rd = 5'd4;
    #1 check("sq_no_credit_stall", {31'b0, stall}, 32'h1);
    step();
    idle();
    #1 check("sq_busy_after", busy_mask, 32'h0);
    check("sq_err_clear", {31'b0, err}, 32'h0);
    wb_valid = 1; wb_rd = 5'd4;
    step();
    idle();
    #1 check("uf_err", {31'b0, err}, 32'h1);
    check("uf_busy", busy_mask, 32'h0);
    step();
    #1 check("uf_err_sticky", {31'b0, err}, 32'h1);

    // Register 0 never tracked
    issue_write(5'd0); use_rs = 1; issue_rs = 5'd0;
    #1 check("r0_stall", {31'b0, stall}, 32'h0);
    step();
    idle();
    #1 check("r0_busy", busy_mask, 32'h0);

    // Pending on 3, 8, 31 then reset overriding a same-cycle issue
    issue_write(5'd3);
    step();
    issue_write(5'd8);
    step();
    issue_write(5'd12); issue_jal = 1;
    step();
    idle();
    #1 check("pre_rst_busy", busy_mask, 32'h8000_0108);
    use_rs = 1; issue_rs = 5'd3;
    #1 check("stall_no_valid", {31'b0, stall}, 32'h0);
    issue_write(5'd10);
    rst = 1;
    step();
    rst = 0;
    idle();
    #1 check("rst_busy", busy_mask, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
